// File: rtl/stream_mux_rr_if.sv
// Stream bundle between CHANNELS producers, the mux and one shared consumer.
// slave is the mux side; master is the producer/consumer side.
interface stream_mux_rr_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_last;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_chan
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_chan
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel packet-aware stream mux with manual or round-robin selection.
// The granted channel stays locked until its in_last beat; the output is registered.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic             busy,
  stream_mux_rr_if.slave   bus
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                     state;
  logic [SEL_W-1:0]               grant, last_grant, rr_pick, next_grant;
  logic                           rr_found, sel_ok, manual_hit, start;
  logic                           load_ok, in_fire;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;

  // Cyclic index base+1+k, folded back into 0..CHANNELS-1.
  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
    int c;
    c = int'(base) + 1 + k;
    if (c >= CHANNELS) c = c - CHANNELS;
    if (c >= CHANNELS) c = c - CHANNELS;
    return SEL_W'(c);
  endfunction

  assign load_ok = !bus.out_valid || bus.out_ready;
  assign busy    = (state == LOCKED);
  assign in_fire = (state == LOCKED) && load_ok && bus.in_valid[grant];

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      assign ch_data[g]      = bus.in_data[g*WIDTH +: WIDTH];
      assign bus.in_ready[g] = (state == LOCKED) && (grant == SEL_W'(g)) && load_ok;
    end
  endgenerate

  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!rr_found && bus.in_valid[rr_idx(last_grant, k)]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx(last_grant, k);
      end
    end
  end

  // An out-of-range manual select never grants.
  assign sel_ok     = (int'(sel) < CHANNELS);
  assign manual_hit = sel_ok && bus.in_valid[sel];
  assign start      = mode ? rr_found : manual_hit;
  assign next_grant = mode ? rr_pick : sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= SEL_W'(CHANNELS - 1);
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_chan  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          grant <= next_grant;
          state <= LOCKED;
        end
        LOCKED: if (in_fire && bus.in_last[grant]) begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (in_fire) begin
        bus.out_data  <= ch_data[grant];
        bus.out_last  <= bus.in_last[grant];
        bus.out_chan  <= grant;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Scenario bench for stream_mux_rr: producer model per channel feeding the DUT,
// expected beats queued at load time and matched against the output stream.
module tb_stream_mux_rr;
  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode, mode3;
  logic [1:0] sel, sel3;
  logic       busy, busy3;
  int         checks = 0;
  int         errors = 0;

  exp_t       sb_q[$];
  exp_t       exp_beat;
  logic [7:0] pdata[4][32];
  logic       plast[4][32];
  int         pcnt[4];
  int         pptr[4];

  stream_mux_rr_if #(.WIDTH(8), .CHANNELS(4)) bus ();
  stream_mux_rr_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .busy(busy), .bus(bus)
  );

  stream_mux_rr #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .busy(busy3), .bus(bus3)
  );

  always #5 clk = ~clk;

  // Output scoreboard and ready sanity, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got chan %0d data %h last %b, expected no beat",
                 bus.out_chan, bus.out_data, bus.out_last);
      end else begin
        exp_beat = sb_q.pop_front();
        if ({bus.out_chan, bus.out_data, bus.out_last} !== exp_beat) begin
          errors++;
          $display("FAIL sb_beat: got chan %0d data %h last %b, expected chan %0d data %h last %b",
                   bus.out_chan, bus.out_data, bus.out_last,
                   exp_beat.chan, exp_beat.data, exp_beat.last);
        end
      end
    end
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(bus.in_ready)) begin
        errors++;
        $display("FAIL ready_onehot: in_ready %b, expected one-hot or zero", bus.in_ready);
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = pptr[i] < pcnt[i];
      bus.in_valid[i]       = v;
      bus.in_data[i*8 +: 8] = v ? pdata[i][pptr[i]] : 8'h00;
      bus.in_last[i]        = v ? plast[i][pptr[i]] : 1'b0;
    end
  endtask

  task automatic clear_prod();
    for (int i = 0; i < 4; i++) begin
      pcnt[i] = 0;
      pptr[i] = 0;
    end
    refresh();
  endtask

  task automatic load(input int ch, input logic [7:0] d, input logic l, input bit expect_out);
    pdata[ch][pcnt[ch]] = d;
    plast[ch][pcnt[ch]] = l;
    pcnt[ch]++;
    if (expect_out) sb_q.push_back({2'(ch), d, l});
  endtask

  // One clock: sample handshakes at negedge, advance producers 1ns after posedge.
  task automatic step();
    logic [3:0] fired;
    @(negedge clk);
    for (int i = 0; i < 4; i++) fired[i] = rst_n && bus.in_valid[i] && bus.in_ready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (fired[i]) pptr[i]++;
    refresh();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || bus.out_valid !== 1'b0) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 8'h10 + 8'(i), 1'b1, 1'b1);
    refresh();
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_chan, busy, bus.in_ready} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: valid %b data %h last %b chan %0d busy %b ready %b, required all 0",
                 bus.out_valid, bus.out_data, bus.out_last, bus.out_chan, busy, bus.in_ready);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: busy %b in_ready %b, required 1 / 0001", busy, bus.in_ready);
    end
    drain("reset");
  endtask

  task automatic test_round_robin();
    clear_prod();
    mode = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) load(i, 8'h40 + 8'(r*4 + i), 1'b1, 1'b1);
    refresh();
    // One-beat packets: beat, bubble, beat, ... starting after the grant cycle.
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (bus.out_valid !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL rr_cadence: cycle %0d out_valid %b, required %b", k, bus.out_valid, (k % 2) == 0);
      end
    end
    drain("rr");
  endtask

  task automatic test_manual();
    clear_prod();
    mode = 1'b0;
    sel  = 2'd2;
    load(2, 8'hA1, 1'b0, 1'b1);
    load(2, 8'hA2, 1'b0, 1'b1);
    load(2, 8'hA3, 1'b1, 1'b1);
    refresh();
    step();
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL manual_grant: busy %b in_ready %b, required 1 / 0100", busy, bus.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || busy !== (k != 2)) begin
        errors++;
        $display("FAIL manual_stream: beat %0d out_valid %b busy %b, required 1 / %b",
                 k, bus.out_valid, busy, k != 2);
      end
    end
    drain("manual");
  endtask

  task automatic test_backpressure();
    clear_prod();
    mode = 1'b0;
    sel  = 2'd1;
    for (int i = 0; i < 4; i++) load(1, 8'hB0 + 8'(i), i == 3, 1'b1);
    refresh();
    step(); step(); step();
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000 || bus.out_data !== 8'hB1) begin
      errors++;
      $display("FAIL bp_enter: in_ready %b out_data %h, required 0000 / b1", bus.in_ready, bus.out_data);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.out_data !== 8'hB1 || bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d data %h valid %b in_ready %b, required b1 / 1 / 0000",
                 k, bus.out_data, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    drain("bp");
  endtask

  task automatic test_sel_change();
    clear_prod();
    mode = 1'b0;
    sel  = 2'd1;
    for (int i = 0; i < 3; i++) load(1, 8'hC0 + 8'(i), i == 2, 1'b1);
    load(3, 8'hD0, 1'b0, 1'b1);
    load(3, 8'hD1, 1'b1, 1'b1);
    refresh();
    step();
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL selchg_grant: in_ready %b, required 0010", bus.in_ready);
    end
    step();
    sel = 2'd3;
    step(); step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL selchg_idle: busy %b, required 0", busy);
    end
    step();
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL selchg_regrant: busy %b in_ready %b, required 1 / 1000", busy, bus.in_ready);
    end
    drain("selchg");
  endtask

  task automatic test_no_grant();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (busy3 !== 1'b0 || bus3.in_ready !== 3'b000 || bus3.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sel_out_of_range: busy %b in_ready %b out_valid %b, required 0 / 000 / 0",
                 busy3, bus3.in_ready, bus3.out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_prod();
    mode = 1'b0;
    sel  = 2'd0;
    for (int i = 0; i < 4; i++) load(0, 8'hE0 + 8'(i), i == 3, 1'b0);
    refresh();
    step(); step();
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: out_valid %b busy %b in_ready %b, required 0 / 0 / 0000",
               bus.out_valid, busy, bus.in_ready);
    end
    clear_prod();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    load(0, 8'hF0, 1'b0, 1'b1);
    load(0, 8'hF1, 1'b0, 1'b1);
    load(0, 8'hF2, 1'b1, 1'b1);
    refresh();
    drain("reset_mid");
  endtask

  initial begin
    rst_n          = 1'b0;
    mode           = 1'b1;
    sel            = 2'd0;
    bus.out_ready  = 1'b1;
    mode3          = 1'b0;
    sel3           = 2'd3;
    bus3.in_valid  = 3'b111;
    bus3.in_last   = 3'b111;
    bus3.in_data   = 24'h5a5a5a;
    bus3.out_ready = 1'b1;
    clear_prod();
    test_reset();
    test_round_robin();
    test_manual();
    test_backpressure();
    test_sel_change();
    test_no_grant();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
